// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master Wishbone arbiter with a round-robin tie break and a stall watchdog.
// Latency: a request seen in IDLE owns the downstream port one cycle later; the datapath is combinational while granted.
// Backpressure: the losing master stalls with ack=0. A slave that never acks is terminated after TIMEOUT_CYCLES strobe cycles.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   io_wbs_*_m0 / io_wbs_*_m1 master-side Wishbone (adr, datwr, datrd, we, stb, cyc, ack)
//   io_wbs_*                  downstream Wishbone port towards the address decoder
//   grant_o                   one-hot current owner {m1,m0}; 2'b00 while idle
//   timeout_o                 high for the one cycle in which the watchdog terminates a cycle
module wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // master 0 (management SoC)
  input  logic [31:0] io_wbs_adr_m0,
  input  logic [31:0] io_wbs_datwr_m0,
  output logic [31:0] io_wbs_datrd_m0,
  input  logic        io_wbs_we_m0,
  input  logic        io_wbs_stb_m0,
  input  logic        io_wbs_cyc_m0,
  output logic        io_wbs_ack_m0,
  // master 1 (internal sequencer/DMA)
  input  logic [31:0] io_wbs_adr_m1,
  input  logic [31:0] io_wbs_datwr_m1,
  output logic [31:0] io_wbs_datrd_m1,
  input  logic        io_wbs_we_m1,
  input  logic        io_wbs_stb_m1,
  input  logic        io_wbs_cyc_m1,
  output logic        io_wbs_ack_m1,
  // downstream port
  output logic [31:0] io_wbs_adr,
  output logic [31:0] io_wbs_datwr,
  input  logic [31:0] io_wbs_datrd,
  output logic        io_wbs_we,
  output logic        io_wbs_stb,
  output logic        io_wbs_cyc,
  input  logic        io_wbs_ack,
  // status
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  // Counter value seen on the final silent strobe cycle before a forced ack.
  localparam logic [15:0] LP_WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last_grant;       // 1: m1 owned the bus last, so m0 wins the next tie
  logic        w_next_last_grant;
  logic [15:0] r_wd_cnt;
  logic [15:0] w_next_wd_cnt;

  logic w_req0;
  logic w_req1;
  logic w_g0;
  logic w_g1;
  logic w_gnt_stb;
  logic w_force;

  assign w_req0    = io_wbs_cyc_m0 & io_wbs_stb_m0;
  assign w_req1    = io_wbs_cyc_m1 & io_wbs_stb_m1;
  assign w_g0      = (r_state == GRANT0);
  assign w_g1      = (r_state == GRANT1);
  assign w_gnt_stb = (w_g0 & io_wbs_stb_m0) | (w_g1 & io_wbs_stb_m1);
  // A real ack in the same cycle always beats the watchdog.
  assign w_force   = w_gnt_stb & ~io_wbs_ack & (r_wd_cnt == LP_WD_LAST);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_wd_cnt     <= '0;
    end else begin
      r_state      <= w_next_state;
      r_last_grant <= w_next_last_grant;
      r_wd_cnt     <= w_next_wd_cnt;
    end
  end

  // Next-state, round-robin memory and watchdog counter.
  always_comb begin
    w_next_state      = r_state;
    w_next_last_grant = r_last_grant;
    w_next_wd_cnt     = '0;
    case (r_state)
      IDLE: begin
        if (w_req0 & (~w_req1 | r_last_grant)) begin
          w_next_state = GRANT0;
        end else if (w_req1) begin
          w_next_state = GRANT1;
        end
      end
      GRANT0: begin
        if (!io_wbs_cyc_m0) begin
          w_next_state      = IDLE;
          w_next_last_grant = 1'b0;
        end
      end
      GRANT1: begin
        if (!io_wbs_cyc_m1) begin
          w_next_state      = IDLE;
          w_next_last_grant = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
    // Count only consecutive silent strobe cycles of the owner that keeps the bus.
    if (w_gnt_stb && !io_wbs_ack && !w_force && (w_next_state != IDLE)) begin
      w_next_wd_cnt = r_wd_cnt + 16'd1;
    end
  end

  // Combinational datapath steering towards the current owner.
  always_comb begin
    io_wbs_adr      = '0;
    io_wbs_datwr    = '0;
    io_wbs_we       = 1'b0;
    io_wbs_stb      = 1'b0;
    io_wbs_cyc      = 1'b0;
    io_wbs_ack_m0   = 1'b0;
    io_wbs_ack_m1   = 1'b0;
    io_wbs_datrd_m0 = '0;
    io_wbs_datrd_m1 = '0;
    grant_o         = 2'b00;
    timeout_o       = w_force;
    if (w_g0) begin
      io_wbs_adr      = io_wbs_adr_m0;
      io_wbs_datwr    = io_wbs_datwr_m0;
      io_wbs_we       = io_wbs_we_m0;
      io_wbs_cyc      = io_wbs_cyc_m0;
      io_wbs_stb      = io_wbs_stb_m0 & ~w_force;
      io_wbs_ack_m0   = io_wbs_ack | w_force;
      io_wbs_datrd_m0 = w_force ? TIMEOUT_DATA : io_wbs_datrd;
      grant_o         = 2'b01;
    end else if (w_g1) begin
      io_wbs_adr      = io_wbs_adr_m1;
      io_wbs_datwr    = io_wbs_datwr_m1;
      io_wbs_we       = io_wbs_we_m1;
      io_wbs_cyc      = io_wbs_cyc_m1;
      io_wbs_stb      = io_wbs_stb_m1 & ~w_force;
      io_wbs_ack_m1   = io_wbs_ack | w_force;
      io_wbs_datrd_m1 = w_force ? TIMEOUT_DATA : io_wbs_datrd;
      grant_o         = 2'b10;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed master/slave vectors, a bus-ownership model
// checked on every falling edge, and literal expectations at key cycles.
module tb_wb_arbiter;
  localparam int          TO    = 8;
  localparam logic [31:0] TDATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr0, dw0, adr1, dw1, dr;
  logic        we0, stb0, cyc0, we1, stb1, cyc1, ack;
  logic [31:0] dr0, dr1, adr, dw;
  logic        ack0, ack1, we, stb, cyc, tmo;
  logic [1:0]  grant;

  int n_vec = 0;
  int n_err = 0;

  // Model: who owns the bus (-1 none), who owned it last, and how many
  // silent strobe cycles the current owner has already waited through.
  int m_owner = -1;
  int m_last  = 1;
  int m_wd    = 0;

  wb_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(TDATA)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .io_wbs_adr_m0(adr0), .io_wbs_datwr_m0(dw0), .io_wbs_datrd_m0(dr0),
    .io_wbs_we_m0(we0), .io_wbs_stb_m0(stb0), .io_wbs_cyc_m0(cyc0), .io_wbs_ack_m0(ack0),
    .io_wbs_adr_m1(adr1), .io_wbs_datwr_m1(dw1), .io_wbs_datrd_m1(dr1),
    .io_wbs_we_m1(we1), .io_wbs_stb_m1(stb1), .io_wbs_cyc_m1(cyc1), .io_wbs_ack_m1(ack1),
    .io_wbs_adr(adr), .io_wbs_datwr(dw), .io_wbs_datrd(dr),
    .io_wbs_we(we), .io_wbs_stb(stb), .io_wbs_cyc(cyc), .io_wbs_ack(ack),
    .grant_o(grant), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // The owner's strobe is the TO-th in a row with no slave ack.
  function automatic logic m_force();
    logic gs;
    gs = (m_owner == 0) ? stb0 : (m_owner == 1) ? stb1 : 1'b0;
    return (m_owner >= 0) && gs && !ack && (m_wd + 1 == TO);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1;
      m_last  <= 1;
      m_wd    <= 0;
    end else if (m_owner < 0) begin
      m_wd <= 0;
      if ((cyc0 && stb0) && (cyc1 && stb1)) m_owner <= (m_last == 1) ? 0 : 1;
      else if (cyc0 && stb0)                m_owner <= 0;
      else if (cyc1 && stb1)                m_owner <= 1;
    end else begin
      logic gcyc, gstb, f;
      gcyc = (m_owner == 0) ? cyc0 : cyc1;
      gstb = (m_owner == 0) ? stb0 : stb1;
      f    = m_force();
      if (!gcyc) begin
        m_last  <= m_owner;
        m_owner <= -1;
        m_wd    <= 0;
      end else if (gstb && !ack && !f) begin
        m_wd <= m_wd + 1;
      end else begin
        m_wd <= 0;
      end
    end
  end

  always @(negedge clk) begin
    logic f;
    logic [31:0] e_adr, e_dw, e_dr0, e_dr1;
    logic e_we, e_cyc, e_stb, e_ack0, e_ack1;
    logic [1:0] e_gnt;
    f = m_force();
    e_adr = '0; e_dw = '0; e_we = 1'b0; e_cyc = 1'b0; e_stb = 1'b0;
    e_ack0 = 1'b0; e_ack1 = 1'b0; e_dr0 = '0; e_dr1 = '0; e_gnt = 2'b00;
    if (m_owner == 0) begin
      e_adr = adr0; e_dw = dw0; e_we = we0; e_cyc = cyc0; e_stb = stb0 & !f;
      e_ack0 = ack | f; e_dr0 = f ? TDATA : dr; e_gnt = 2'b01;
    end else if (m_owner == 1) begin
      e_adr = adr1; e_dw = dw1; e_we = we1; e_cyc = cyc1; e_stb = stb1 & !f;
      e_ack1 = ack | f; e_dr1 = f ? TDATA : dr; e_gnt = 2'b10;
    end
    chk("model grant", 32'(grant), 32'(e_gnt));
    chk("model adr", adr, e_adr);
    chk("model datwr", dw, e_dw);
    chk("model we/cyc/stb", 32'({we, cyc, stb}), 32'({e_we, e_cyc, e_stb}));
    chk("model ack_m0", 32'(ack0), 32'(e_ack0));
    chk("model ack_m1", 32'(ack1), 32'(e_ack1));
    chk("model datrd_m0", dr0, e_dr0);
    chk("model datrd_m1", dr1, e_dr1);
    chk("model timeout", 32'(tmo), 32'(f));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic c, input logic s, input logic w, input logic [31:0] a, input logic [31:0] d);
    cyc0 = c; stb0 = s; we0 = w; adr0 = a; dw0 = d;
  endtask

  task automatic set1(input logic c, input logic s, input logic w, input logic [31:0] a, input logic [31:0] d);
    cyc1 = c; stb1 = s; we1 = w; adr1 = a; dw1 = d;
  endtask

  task automatic slv(input logic a, input logic [31:0] d);
    ack = a; dr = d;
  endtask

  initial begin
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    slv(0, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset grant", 32'(grant), 32'h0);
    chk("reset cyc/stb", 32'({cyc, stb}), 32'h0);
    chk("reset acks", 32'({ack0, ack1}), 32'h0);
    chk("reset timeout", 32'(tmo), 32'h0);
    // A stray slave ack while idle reaches nobody.
    slv(1, 32'h5555_0000);
    #1 chk("idle late ack", 32'({ack0, ack1}), 32'h0);
    tick(); slv(0, 0);

    // 1: single m0 write, slave acks two cycles after the first strobe.
    set0(1, 1, 1, 32'h3000_0004, 32'hA5A5_0001);
    #1 chk("t1 idle stb", 32'(stb), 32'h0);
    tick();
    chk("t1 grant", 32'(grant), 32'h1);
    chk("t1 stb", 32'(stb), 32'h1);
    chk("t1 adr", adr, 32'h3000_0004);
    chk("t1 datwr", dw, 32'hA5A5_0001);
    tick();
    chk("t1 wait ack", 32'(ack0), 32'h0);
    tick();
    slv(1, 0);
    #1 chk("t1 ack_m0", 32'(ack0), 32'h1);
    tick(); slv(0, 0); set0(0, 0, 0, 0, 0);
    tick();
    chk("t1 back to idle", 32'(grant), 32'h0);

    // 2: simultaneous requests straight out of reset.
    rst = 1'b1; tick(); rst = 1'b0;
    set0(1, 1, 0, 32'h3000_0100, 0);
    set1(1, 1, 0, 32'h3000_0200, 0);
    tick();
    chk("t2 first tie m0", 32'(grant), 32'h1);
    chk("t2 m0 adr", adr, 32'h3000_0100);
    slv(1, 32'h1111_2222);
    #1 chk("t2 datrd_m0", dr0, 32'h1111_2222);
    chk("t2 ack_m1 stalled", 32'(ack1), 32'h0);
    tick(); slv(0, 0); set0(0, 0, 0, 0, 0);
    tick();
    chk("t2 dead cycle", 32'(grant), 32'h0);
    tick();
    chk("t2 m1 granted", 32'(grant), 32'h2);
    chk("t2 m1 adr", adr, 32'h3000_0200);
    slv(1, 32'h3333_4444);
    #1 chk("t2 datrd_m1", dr1, 32'h3333_4444);
    tick(); slv(0, 0); set1(0, 0, 0, 0, 0);
    tick();
    set0(1, 1, 0, 32'h3000_0300, 0);
    set1(1, 1, 0, 32'h3000_0400, 0);
    tick();
    chk("t2 second tie m0", 32'(grant), 32'h1);
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
    tick(); tick();

    // 3: m1 keeps the grant across four back-to-back reads.
    set1(1, 1, 0, 32'h0000_0100, 0);
    tick();
    set0(1, 1, 1, 32'h3000_0010, 32'h0000_CAFE);
    for (int i = 0; i < 4; i++) begin
      set1(1, 1, 0, 32'h0000_0100 + 32'(4 * i), 0);
      slv(1, 32'hB000_0000 + 32'(i));
      #1;
      chk("t3 grant m1", 32'(grant), 32'h2);
      chk("t3 datrd_m1", dr1, 32'hB000_0000 + 32'(i));
      chk("t3 ack_m0 stalled", 32'(ack0), 32'h0);
      tick();
    end
    set1(0, 0, 0, 0, 0); slv(0, 0);
    tick();
    chk("t3 dead cycle", 32'(grant), 32'h0);
    tick();
    chk("t3 m0 finally", 32'(grant), 32'h1);
    slv(1, 0);
    tick(); slv(0, 0); set0(0, 0, 0, 0, 0);
    tick(); tick();

    // 4: silent slave, watchdog fires on the TO-th strobe cycle.
    set0(1, 1, 0, 32'h3000_0F00, 0);
    tick();
    for (int k = 1; k <= TO; k++) begin
      #1;
      if (k < TO) begin
        chk("t4 no early timeout", 32'(tmo), 32'h0);
        tick();
      end else begin
        chk("t4 forced ack", 32'(ack0), 32'h1);
        chk("t4 timeout data", dr0, 32'hDEAD_BEEF);
        chk("t4 timeout pulse", 32'(tmo), 32'h1);
        chk("t4 stb masked", 32'(stb), 32'h0);
      end
    end
    tick(); set0(0, 0, 0, 0, 0);
    #1 chk("t4 pulse ends", 32'(tmo), 32'h0);
    tick(); tick();

    // 5: real ack lands in the would-be force cycle.
    set0(1, 1, 0, 32'h3000_0F04, 0);
    tick();
    for (int k = 1; k < TO; k++) tick();
    slv(1, 32'h1234_5678);
    #1;
    chk("t5 real data", dr0, 32'h1234_5678);
    chk("t5 no timeout", 32'(tmo), 32'h0);
    chk("t5 stb kept", 32'(stb), 32'h1);
    tick(); slv(0, 0); set0(0, 0, 0, 0, 0);
    tick(); tick();

    // 6: reset in the middle of a granted m1 cycle.
    set1(1, 1, 1, 32'h3000_0020, 32'h0000_0077);
    tick();
    chk("t6 m1 granted", 32'(grant), 32'h2);
    slv(1, 0);
    #1 rst = 1'b1;
    #1;
    chk("t6 rst grant", 32'(grant), 32'h0);
    chk("t6 rst cyc/stb", 32'({cyc, stb}), 32'h0);
    chk("t6 rst acks", 32'({ack0, ack1}), 32'h0);
    tick();
    rst = 1'b0; slv(0, 0);
    set0(1, 1, 0, 32'h3000_0030, 0);
    tick();
    chk("t6 tie after reset", 32'(grant), 32'h1);
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
